bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max BUSY cycles without i_ack before forced termination; legal range 1..65535.
REQ-002 SHALL have ports i_clk input 1: sole clock, all state on rising edge.
REQ-003 SHALL have port i_reset_n input 1: asynchronous active-low reset.
REQ-004 SHALL have ports i_m0_cs/i_m1_cs/i_m2_cs input 1 each: request/strobe; m0=VGA, m1=UART master, m2=CPU.
REQ-005 SHALL have ports i_mN_we input 1, i_mN_addr input 16, i_mN_dat input 8 per master: write enable, address, write data.
REQ-006 SHALL have ports o_mN_ack output 1, o_mN_err output 1 per master: transfer done, transfer timed out.
REQ-007 SHALL have ports o_cs output 1, o_we output 1, o_addr output 16, o_dat output 8, i_ack input 1: shared memory bus.
REQ-008 SHALL have port o_rdat output 8: read data, common to all masters; master-specific ack qualifies it.
REQ-009 SHALL have port o_gnt output 3: registered one-hot grant, bit N = master N.

Function
REQ-010 SHALL implement states IDLE and BUSY; reset enters IDLE.
REQ-011 IDLE: if any i_mN_cs high, SHALL register winner into o_gnt and go BUSY next edge; else stay IDLE with o_gnt=0.
REQ-012 Winner selection SHALL be fixed priority m0 > m1 > m2 unless REQ-025 applies.
REQ-013 In BUSY, o_cs/o_we/o_addr/o_dat SHALL combinationally follow the granted master's inputs; in IDLE all SHALL be 0.
REQ-014 o_mN_ack SHALL equal i_ack AND o_gnt[N] AND i_mN_cs, combinationally; non-granted masters SHALL see ack=0.
REQ-015 o_rdat SHALL pass i_ack-time read data from bus input i_dat combinationally (port i_dat input 8); forced to 8'hFF on timeout cycle.
REQ-016 BUSY -> IDLE SHALL occur on the edge where the granted master's cs is low; grant clears that edge; re-arbitration needs one IDLE cycle (minimum 1 idle cycle between grants).
REQ-017 Grant SHALL NOT change while BUSY, regardless of higher-priority requests.
REQ-018 A 16-bit wait counter SHALL clear on entering BUSY and on every cycle with i_ack high, and increment each BUSY cycle with cs high and i_ack low.
REQ-019 When counter equals TIMEOUT and i_ack is low, SHALL assert o_mN_ack and o_mN_err for the granted master for exactly one cycle, with o_rdat=8'hFF, and clear counter.
REQ-020 i_ack and timeout in same cycle: i_ack SHALL win, o_mN_err=0.
REQ-021 Granted cs dropping before any ack SHALL return to IDLE with no ack and no err.
REQ-022 o_cs SHALL be 0 on the timeout cycle.

Reset
REQ-023 i_reset_n low SHALL immediately force state IDLE, o_gnt=0, counter=0, and thereby o_cs=0, o_we=0, o_addr=0, o_dat=0, all ack/err=0, regardless of clock.
REQ-024 Reset mid-BUSY SHALL abandon the transfer without ack; first arbitration occurs on the first edge after i_reset_n rises.

Configuration
REQ-025 With BUS_ARBITER_RR_EN defined, SHALL use round-robin: search order starts at master after last granted (mod 3), last-granted register resets to m2 (so m0 first); without it, fixed priority per REQ-012 and no last-granted register.

Verification
REQ-026 All three cs asserted in IDLE -> o_gnt=3'b001 next cycle; without RR, m0 regranted every transfer while it keeps requesting.
REQ-027 m2 write addr 16'h1234 dat 8'hA5, i_ack after 3 cycles -> o_addr/o_dat/o_we match, o_m2_ack one cycle, o_m0_ack=o_m1_ack=0.
REQ-028 m1 read, i_ack never asserted, TIMEOUT=4 -> o_m1_ack and o_m1_err pulse on 5th BUSY cycle, o_rdat=8'hFF, o_cs=0 that cycle.
REQ-029 m2 BUSY, m0 raises cs -> o_gnt stays 3'b100 until m2 cs low, then 3'b001 after one idle cycle.
REQ-030 i_reset_n low mid-transfer -> o_gnt=0, o_cs=0 without waiting for clock edge; no ack issued.
REQ-031 With BUS_ARBITER_RR_EN, all three continuously requesting -> grant sequence m0, m1, m2, m0.

Source files
------------

// File: rtl/bus_arbiter.sv
// Three-master arbiter for a shared 16-bit-address / 8-bit-data memory bus with a wait timeout.
// Fixed priority m0 > m1 > m2 by default; define BUS_ARBITER_RR_EN for round-robin arbitration.
module bus_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_reset_n,

    input  logic        i_m0_cs,
    input  logic        i_m0_we,
    input  logic [15:0] i_m0_addr,
    input  logic [7:0]  i_m0_dat,
    output logic        o_m0_ack,
    output logic        o_m0_err,

    input  logic        i_m1_cs,
    input  logic        i_m1_we,
    input  logic [15:0] i_m1_addr,
    input  logic [7:0]  i_m1_dat,
    output logic        o_m1_ack,
    output logic        o_m1_err,

    input  logic        i_m2_cs,
    input  logic        i_m2_we,
    input  logic [15:0] i_m2_addr,
    input  logic [7:0]  i_m2_dat,
    output logic        o_m2_ack,
    output logic        o_m2_err,

    output logic        o_cs,
    output logic        o_we,
    output logic [15:0] o_addr,
    output logic [7:0]  o_dat,
    input  logic        i_ack,
    input  logic [7:0]  i_dat,
    output logic [7:0]  o_rdat,
    output logic [2:0]  o_gnt
);

    localparam int unsigned NM = 3;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] dat;
    } req_t;

    state_e        state_q, state_d;
    logic [NM-1:0] gnt_q, gnt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [NM-1:0] cs_vec_c;
    logic [NM-1:0] win_c;
    logic          gnt_cs_c;
    logic          timeout_c;
    req_t          req_c [NM];
    req_t          sel_c;

    assign cs_vec_c = {i_m2_cs, i_m1_cs, i_m0_cs};
    assign req_c[0] = {i_m0_we, i_m0_addr, i_m0_dat};
    assign req_c[1] = {i_m1_we, i_m1_addr, i_m1_dat};
    assign req_c[2] = {i_m2_we, i_m2_addr, i_m2_dat};

    assign gnt_cs_c  = |(gnt_q & cs_vec_c);
    // A simultaneous i_ack always beats the timeout.
    assign timeout_c = (state_q == BUSY) && gnt_cs_c && !i_ack && (cnt_q == CW'(TIMEOUT));

`ifdef BUS_ARBITER_RR_EN
    logic [1:0] last_q, last_d;

    // Round-robin: search starts at the master after the last one granted.
    always_comb begin
        win_c = '0;
        case (last_q)
            2'd0: begin
                if      (cs_vec_c[1]) win_c = 3'b010;
                else if (cs_vec_c[2]) win_c = 3'b100;
                else if (cs_vec_c[0]) win_c = 3'b001;
            end
            2'd1: begin
                if      (cs_vec_c[2]) win_c = 3'b100;
                else if (cs_vec_c[0]) win_c = 3'b001;
                else if (cs_vec_c[1]) win_c = 3'b010;
            end
            default: begin
                if      (cs_vec_c[0]) win_c = 3'b001;
                else if (cs_vec_c[1]) win_c = 3'b010;
                else if (cs_vec_c[2]) win_c = 3'b100;
            end
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (state_q == IDLE && |cs_vec_c) begin
            case (win_c)
                3'b010:  last_d = 2'd1;
                3'b100:  last_d = 2'd2;
                default: last_d = 2'd0;
            endcase
        end
    end

    // Resets to m2 so that m0 is searched first.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) last_q <= 2'd2;
        else            last_q <= last_d;
    end
`else
    always_comb begin
        win_c = '0;
        if      (cs_vec_c[0]) win_c = 3'b001;
        else if (cs_vec_c[1]) win_c = 3'b010;
        else if (cs_vec_c[2]) win_c = 3'b100;
    end
`endif

    // Next-state: grant is held for the whole BUSY phase, wait counter tracks unacked cycles.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (|cs_vec_c) begin
                    gnt_d   = win_c;
                    state_d = BUSY;
                end else begin
                    gnt_d = '0;
                end
            end
            BUSY: begin
                if (!gnt_cs_c) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                end else if (i_ack || timeout_c) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
        end
    end

    // Bus mux: grant is zero outside BUSY, so everything reads as zero in IDLE and reset.
    always_comb begin
        sel_c = '0;
        case (gnt_q)
            3'b001:  sel_c = req_c[0];
            3'b010:  sel_c = req_c[1];
            3'b100:  sel_c = req_c[2];
            default: sel_c = '0;
        endcase
    end

    assign o_cs   = (state_q == BUSY) && gnt_cs_c && !timeout_c;
    assign o_we   = sel_c.we;
    assign o_addr = sel_c.addr;
    assign o_dat  = sel_c.dat;
    assign o_rdat = timeout_c ? 8'hFF : i_dat;
    assign o_gnt  = gnt_q;

    assign o_m0_ack = gnt_q[0] && i_m0_cs && (i_ack || timeout_c);
    assign o_m1_ack = gnt_q[1] && i_m1_cs && (i_ack || timeout_c);
    assign o_m2_ack = gnt_q[2] && i_m2_cs && (i_ack || timeout_c);
    assign o_m0_err = gnt_q[0] && timeout_c;
    assign o_m1_err = gnt_q[1] && timeout_c;
    assign o_m2_err = gnt_q[2] && timeout_c;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: transaction-level model checked every cycle plus directed literal checks.
module tb_bus_arbiter;

    localparam int TO = 4;
`ifdef BUS_ARBITER_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  m_cs = '0;
    logic [2:0]  m_we = '0;
    logic [15:0] m_addr [3];
    logic [7:0]  m_dat [3];
    logic        i_ack = 1'b0;
    logic [7:0]  i_dat = 8'h77;

    logic        o_m0_ack, o_m0_err, o_m1_ack, o_m1_err, o_m2_ack, o_m2_err;
    logic        o_cs, o_we;
    logic [15:0] o_addr;
    logic [7:0]  o_dat, o_rdat;
    logic [2:0]  o_gnt;
    logic [2:0]  ack_v, err_v;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.TIMEOUT(TO)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_m0_cs(m_cs[0]), .i_m0_we(m_we[0]), .i_m0_addr(m_addr[0]), .i_m0_dat(m_dat[0]),
        .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err),
        .i_m1_cs(m_cs[1]), .i_m1_we(m_we[1]), .i_m1_addr(m_addr[1]), .i_m1_dat(m_dat[1]),
        .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err),
        .i_m2_cs(m_cs[2]), .i_m2_we(m_we[2]), .i_m2_addr(m_addr[2]), .i_m2_dat(m_dat[2]),
        .o_m2_ack(o_m2_ack), .o_m2_err(o_m2_err),
        .o_cs(o_cs), .o_we(o_we), .o_addr(o_addr), .o_dat(o_dat),
        .i_ack(i_ack), .i_dat(i_dat), .o_rdat(o_rdat), .o_gnt(o_gnt)
    );

    assign ack_v = {o_m2_ack, o_m1_ack, o_m0_ack};
    assign err_v = {o_m2_err, o_m1_err, o_m0_err};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model: who owns the bus (-1 = nobody), how long it has waited, who was served last.
    int mo_owner = -1;
    int mo_wait  = 0;
    int mo_last  = 2;

    function automatic int pick(input logic [2:0] cs, input int last);
        int idx;
        pick = -1;
        for (int k = 1; k <= 3; k++) begin
            idx = RR ? (last + k) % 3 : k - 1;
            if (pick < 0 && cs[idx]) pick = idx;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mo_owner <= -1;
            mo_wait  <= 0;
            mo_last  <= 2;
        end else if (mo_owner < 0) begin
            if (pick(m_cs, mo_last) >= 0) begin
                mo_owner <= pick(m_cs, mo_last);
                mo_last  <= pick(m_cs, mo_last);
                mo_wait  <= 0;
            end
        end else if (!m_cs[mo_owner]) begin
            mo_owner <= -1;
        end else if (i_ack || mo_wait == TO) begin
            mo_wait <= 0;
        end else begin
            mo_wait <= mo_wait + 1;
        end
    end

    task automatic compare_cycle();
        logic        tmo = 1'b0;
        logic        own_cs = 1'b0;
        logic [2:0]  eg = '0, ea = '0, ee = '0;
        logic        ecs = 1'b0, ewe = 1'b0;
        logic [15:0] ead = '0;
        logic [7:0]  edt = '0;
        if (mo_owner >= 0) begin
            own_cs = m_cs[mo_owner];
            tmo    = own_cs && !i_ack && (mo_wait == TO);
            eg     = 3'(1 << mo_owner);
            ecs    = own_cs && !tmo;
            ewe    = m_we[mo_owner];
            ead    = m_addr[mo_owner];
            edt    = m_dat[mo_owner];
            if (own_cs && (i_ack || tmo)) ea = eg;
            if (tmo) ee = eg;
        end
        check("cyc_gnt",  32'(o_gnt),  32'(eg));
        check("cyc_cs",   32'(o_cs),   32'(ecs));
        check("cyc_we",   32'(o_we),   32'(ewe));
        check("cyc_addr", 32'(o_addr), 32'(ead));
        check("cyc_dat",  32'(o_dat),  32'(edt));
        check("cyc_ack",  32'(ack_v),  32'(ea));
        check("cyc_err",  32'(err_v),  32'(ee));
        check("cyc_rdat", 32'(o_rdat), tmo ? 32'hFF : 32'(i_dat));
    endtask

    always @(negedge clk) compare_cycle();

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // One acked single-cycle transfer starting from an IDLE cycle with requests pending.
    task automatic xfer(input int who, input logic rereq);
        step();
        i_ack = 1'b1;
        i_dat = 8'h40 + 8'(who);
        smp();
        check("xfer_gnt", 32'(o_gnt), 32'(1 << who));
        check("xfer_ack", 32'(ack_v), 32'(1 << who));
        step();
        i_ack = 1'b0;
        m_cs[who] = 1'b0;
        smp();
        check("xfer_ack_once", 32'(ack_v), 32'h0);
        step();
        m_cs[who] = rereq;
        smp();
        check("xfer_idle_gap", 32'(o_gnt), 32'h0);
    endtask

    int seq [4];

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_addr[i] = 16'h0010 * 16'(i + 1);
            m_dat[i]  = 8'h0;
        end
        if (RR) seq = '{0, 1, 2, 0};
        else    seq = '{0, 0, 0, 0};

        repeat (2) step();
        smp();
        check("rst_gnt", 32'(o_gnt), 32'h0);
        check("rst_cs",  32'(o_cs),  32'h0);
        step();
        rst_n = 1'b1;

        // All three request: m0 first, then RR rotation or m0 re-grant.
        m_cs = 3'b111;
        for (int k = 0; k < 4; k++) xfer(seq[k], k < 3);
        m_cs = 3'b000;

        // m2 write acked on its 4th BUSY cycle.
        m_cs[2] = 1'b1; m_we[2] = 1'b1; m_addr[2] = 16'h1234; m_dat[2] = 8'hA5;
        step();
        smp();
        check("wr_gnt",  32'(o_gnt),  32'h4);
        check("wr_addr", 32'(o_addr), 32'h1234);
        check("wr_dat",  32'(o_dat),  32'hA5);
        check("wr_we",   32'(o_we),   32'h1);
        repeat (3) step();
        i_ack = 1'b1; i_dat = 8'h11;
        smp();
        check("wr_ack", 32'(ack_v), 32'h4);
        check("wr_err", 32'(err_v), 32'h0);
        step();
        i_ack = 1'b0; m_cs[2] = 1'b0; m_we[2] = 1'b0;
        smp();
        check("wr_ack_once", 32'(ack_v), 32'h0);
        step();

        // m1 read never acked: timeout on 5th BUSY cycle.
        m_cs[1] = 1'b1; m_addr[1] = 16'h0BEE; i_dat = 8'h5A;
        repeat (4) step();
        smp();
        check("to_pre_err", 32'(err_v), 32'h0);
        check("to_pre_cs",  32'(o_cs),  32'h1);
        step();
        smp();
        check("to_ack",  32'(ack_v),  32'h2);
        check("to_err",  32'(err_v),  32'h2);
        check("to_rdat", 32'(o_rdat), 32'hFF);
        check("to_cs",   32'(o_cs),   32'h0);
        step();
        m_cs[1] = 1'b0;
        smp();
        check("to_err_once", 32'(err_v), 32'h0);
        step();

        // Ack on the timeout cycle wins.
        m_cs[1] = 1'b1;
        repeat (5) step();
        i_ack = 1'b1; i_dat = 8'h99;
        smp();
        check("race_ack",  32'(ack_v),  32'h2);
        check("race_err",  32'(err_v),  32'h0);
        check("race_rdat", 32'(o_rdat), 32'h99);
        step();
        i_ack = 1'b0; m_cs[1] = 1'b0;
        step();

        // Requester withdraws before any ack.
        m_cs[0] = 1'b1;
        step();
        m_cs[0] = 1'b0;
        smp();
        check("drop_ack", 32'(ack_v), 32'h0);
        check("drop_gnt", 32'(o_gnt), 32'h1);
        step();
        smp();
        check("drop_idle", 32'(o_gnt), 32'h0);

        // Grant held against a higher-priority request.
        m_cs[2] = 1'b1;
        step();
        m_cs[0] = 1'b1;
        smp();
        check("hold_gnt_a", 32'(o_gnt), 32'h4);
        step();
        smp();
        check("hold_gnt_b", 32'(o_gnt), 32'h4);
        step();
        m_cs[2] = 1'b0;
        smp();
        check("hold_gnt_c", 32'(o_gnt), 32'h4);
        step();
        smp();
        check("hold_gap", 32'(o_gnt), 32'h0);
        step();
        smp();
        check("hold_next", 32'(o_gnt), 32'h1);
        step();
        m_cs[0] = 1'b0;
        step();

        // Asynchronous reset mid-transfer.
        m_cs[1] = 1'b1;
        step();
        step();
        #2;
        rst_n = 1'b0;
        i_ack = 1'b1;
        #1;
        check("arst_gnt", 32'(o_gnt), 32'h0);
        check("arst_cs",  32'(o_cs),  32'h0);
        check("arst_ack", 32'(ack_v), 32'h0);
        step();
        rst_n = 1'b1;
        i_ack = 1'b0;
        smp();
        check("arst_rel_idle", 32'(o_gnt), 32'h0);
        step();
        smp();
        check("arst_regrant", 32'(o_gnt), 32'h2);
        step();
        m_cs[1] = 1'b0;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
